// File: rtl/plic_agent_pkg.sv
// plic_agent_pkg: shared state encoding and constants for the PLIC claim agent
package plic_agent_pkg;

    localparam logic [31:0] CLAIM_OFFSET_DEF = 32'h0020_0004;
    localparam logic [3:0]  BE_ALL           = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        CLAIM_REQ,
        CLAIM_WAIT,
        DELIVER,
        SERVICE,
        CMPL_REQ,
        CMPL_WAIT
    } plic_agent_state_e;

    function automatic logic is_wait(plic_agent_state_e s);
        return (s == CLAIM_WAIT) || (s == CMPL_WAIT);
    endfunction

endpackage

// File: rtl/plic_agent_timer.sv
// plic_agent_timer: bus response watchdog, expires after TIMEOUT_CYCLES enabled cycles
module plic_agent_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [7:0] cnt_q;

    assign expire_o = en_i && (cnt_q == 8'(TIMEOUT_CYCLES - 1));

    // count enabled cycles from zero; clear has priority so entry to a wait starts at 0
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else if (clr_i)
            cnt_q <= '0;
        else if (en_i)
            cnt_q <= cnt_q + 8'd1;
    end

endmodule

// File: rtl/plic_claim_agent.sv
// plic_claim_agent: claims PLIC interrupts over the bus, hands IDs to a consumer, completes them.
// Optional claim/spurious statistics counters when PLIC_AGENT_STATS_EN is defined.
module plic_claim_agent
    import plic_agent_pkg::*;
#(
    parameter logic [31:0] PLIC_BASE      = 32'h0000_0000,
    parameter logic [31:0] CLAIM_OFFSET   = CLAIM_OFFSET_DEF,
    parameter int          ID_W           = 5,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            irq_i,
    output logic            req_o,
    output logic [31:0]     addr_o,
    output logic            we_o,
    output logic [3:0]      be_o,
    output logic [31:0]     wdata_o,
    input  logic            rvalid_i,
    input  logic [31:0]     rdata_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [ID_W-1:0] id_o,
    input  logic            done_i,
    output logic            busy_o,
    output logic            err_o,
    input  logic            err_clr_i
`ifdef PLIC_AGENT_STATS_EN
    ,
    output logic [15:0]     claim_cnt_o,
    output logic [15:0]     spurious_cnt_o
`endif
);

    plic_agent_state_e state_q, state_d;
    logic [ID_W-1:0]   id_q;
    logic              err_q;
    logic              busy_q;
    logic              wait_st;
    logic              expire;
    logic              claim_hit;
    logic              timeout_hit;
    logic              rdata_unused;

    assign wait_st      = is_wait(state_q);
    assign claim_hit    = (state_q == CLAIM_WAIT) && rvalid_i && irq_i;
    assign timeout_hit  = wait_st && !rvalid_i && expire;
    assign rdata_unused = ^rdata_i[31:ID_W];

    assign addr_o  = PLIC_BASE + CLAIM_OFFSET;
    assign be_o    = BE_ALL;
    assign wdata_o = we_o ? {{(32-ID_W){1'b0}}, id_q} : '0;
    assign id_o    = id_q;
    assign busy_o  = busy_q;
    assign err_o   = err_q;

    plic_agent_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (!wait_st),
        .en_i    (wait_st),
        .expire_o(expire)
    );

    // next state and bus/stream strobes decoded from the current state
    always_comb begin
        state_d    = state_q;
        req_o      = 1'b0;
        we_o       = 1'b0;
        id_valid_o = 1'b0;
        case (state_q)
            IDLE:       if (irq_i) state_d = CLAIM_REQ;
            CLAIM_REQ: begin
                req_o   = 1'b1;
                state_d = CLAIM_WAIT;
            end
            CLAIM_WAIT: begin
                if (rvalid_i)
                    state_d = irq_i ? DELIVER : IDLE;
                else if (expire)
                    state_d = IDLE;
            end
            DELIVER: begin
                id_valid_o = 1'b1;
                if (id_ready_i) state_d = SERVICE;
            end
            SERVICE:    if (done_i) state_d = CMPL_REQ;
            CMPL_REQ: begin
                req_o   = 1'b1;
                we_o    = 1'b1;
                state_d = CMPL_WAIT;
            end
            CMPL_WAIT:  if (rvalid_i || expire) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // state, busy flag, claimed ID and sticky error; a timeout set beats a same-cycle clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            if (claim_hit)
                id_q <= rdata_i[ID_W-1:0];
            err_q <= timeout_hit ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
        end
    end

`ifdef PLIC_AGENT_STATS_EN
    logic [15:0] claim_cnt_q;
    logic [15:0] spur_cnt_q;
    logic        spur_hit;

    assign spur_hit       = (state_q == CLAIM_WAIT) && rvalid_i && !irq_i;
    assign claim_cnt_o    = claim_cnt_q;
    assign spurious_cnt_o = spur_cnt_q;

    // saturating counts of successful and spurious claims
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            claim_cnt_q <= '0;
            spur_cnt_q  <= '0;
        end else begin
            if (claim_hit && claim_cnt_q != 16'hFFFF)
                claim_cnt_q <= claim_cnt_q + 16'd1;
            if (spur_hit && spur_cnt_q != 16'hFFFF)
                spur_cnt_q <= spur_cnt_q + 16'd1;
        end
    end
`endif

endmodule
